mem_arbiter: RTL
================

# mem_arbiter

Shares one single-port, word-organised memory between the instruction-fetch port and the load/store data port of the RV32I core, which makes a split-phase pipelined core possible. Per cycle it grants at most one requester, converts byte/halfword/word accesses into aligned word accesses with byte enables, and returns sign- or zero-extended load data. It also detects misaligned and illegal accesses. It sits between the core's fetch/MEM stages and the memory macro.

## Interface
- `MEM_LATENCY`, 1: cycles from read issue (`mem_en`=1, `mem_we`=0) to valid `mem_rdata`; legal range 1–4.
- `STARVE_LIMIT`, 4: consecutive cycles fetch may be denied while data wins before fetch is forced to win; legal range 1–15.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req_valid`  in  1  fetch request.
- `if_req_addr`  in  32  fetch byte address.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_rsp_valid`  out  1  one-cycle pulse; `if_rsp_data`/`if_rsp_err` valid.
- `if_rsp_data`  out  32  instruction word.
- `if_rsp_err`  out  1  fetch address misaligned (`addr[1:0]`≠0).
- `d_req_valid`  in  1  data request.
- `d_req_we`  in  1  1 = store, 0 = load.
- `d_req_funct3`  in  3  RV32I width code: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
- `d_req_addr`  in  32  data byte address.
- `d_req_wdata`  in  32  store data, LSB-justified.
- `d_req_ready`  out  1  data request accepted this cycle.
- `d_rsp_valid`  out  1  one-cycle pulse; completion for both loads and stores.
- `d_rsp_data`  out  32  extended load data; 0 for stores and errors.
- `d_rsp_err`  out  1  misaligned access or illegal funct3.
- `mem_en`, `mem_we`  out  1  memory access strobe and write enable.
- `mem_addr`  out  32  word address (`{addr[31:2],2'b00}`).
- `mem_be`  out  4  byte enables; bit i = byte lane i.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rdata`  in  32  read data, valid `MEM_LATENCY` cycles after issue.

## Operation
- States: IDLE, RD_WAIT, RSP.
- **IDLE, arbitration:**
  - If only one port is valid, it is granted.
  - If both are valid, data wins unless `starve_cnt` = `STARVE_LIMIT`, in which case fetch wins.
- **`starve_cnt`:**
  - Increments, saturating, each IDLE cycle fetch is valid but not granted.
  - Clears on a fetch grant, or on any cycle `if_req_valid`=0.
- **Ready signals:** the granted port's `*_req_ready` is 1 combinationally in IDLE; both are 0 in RD_WAIT and RSP.
- **Error check at grant:** no memory access is issued; go to RSP with err=1 and data=0. Error conditions:
  - Fetch with `addr[1:0]`≠0.
  - Halfword access with `addr[0]`=1.
  - Word access with `addr[1:0]`≠0.
  - Load funct3 ∈ {011,110,111}.
  - Store funct3 ≥ 011.
- **Store:**
  - Issue `mem_en`=`mem_we`=1 in the grant cycle.
  - `mem_be`: SB → 1<<addr[1:0]; SH → 0011 or 1100 by `addr[1]`; SW → 1111.
  - `mem_wdata`: byte replicated ×4, halfword ×2, or word as-is.
  - Then go to RSP.
- **Load or fetch:**
  - Issue `mem_en`=1, `mem_we`=0 in the grant cycle.
  - Latch requester id, funct3 and `addr[1:0]`.
  - Go to RD_WAIT, count down `MEM_LATENCY`, then capture `mem_rdata` and go to RSP.
- **Load formatting:**
  - Select the byte/halfword by the latched offset.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
  - Fetch data passes through unformatted.
- **RSP:** pulse the owning port's `*_rsp_valid` for exactly one cycle, then return to IDLE. Responses are not back-pressured.
- **Ordering:** at most one transaction is outstanding; responses return in grant order.

## Timing
- **Reset:**
  - State IDLE, `starve_cnt`=0.
  - All `*_ready`, `*_rsp_valid`, `*_rsp_err`, `mem_en`, `mem_we` = 0.
  - `mem_be`=0; `mem_addr`, `mem_wdata`, `*_rsp_data` = 0.
- **Latency:**
  - Store/error: request accepted in cycle N, `d_rsp_valid` in N+1.
  - Read: accepted in N, rsp in N+1+`MEM_LATENCY`.
- **Throughput:** store/error one per 2 cycles; read one per 2+`MEM_LATENCY` cycles.
- **Memory outputs:** `mem_*` outputs are combinational from the grant; they are 0/inactive when no grant occurs.
- **Reset mid-transaction:** `rst` in RD_WAIT or RSP aborts the transaction. No response pulse is emitted, and `mem_rdata` arriving afterwards is ignored.
- **Request stability:** requests must hold stable until ready. A valid dropped before ready is simply not granted.

## Structure
- Package `mem_arb_pkg`: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, requester-id encoding (REQ_IF, REQ_D).
- Sub-module `load_align`: combinational byte/halfword select and extension (rdata, offset, funct3 → data). It is reused by a future cache.

## Test plan
- **Store then load:** SW 0xDEADBEEF @0x00200000, then LB @0x00200003 → `mem_be`=1111; load returns 0xFFFFFFDE.
- **Sub-word store:** SH 0x1234ABCD @0x00200006 → `mem_be`=1100, `mem_wdata`=0xABCDABCD. Following LHU @0x00200006 → 0x0000ABCD; LH → 0xFFFFABCD.
- **Misaligned:** LW @0x00200002 → no `mem_en`, `d_rsp_err`=1, data 0 at N+1. Fetch @0x00000006 → `if_rsp_err`=1.
- **Starvation:** both ports continuously valid, STARVE_LIMIT=4 → fetch is granted on every 5th grant opportunity; no port waits unbounded.
- **Latency sweep:** `MEM_LATENCY`=3, back-to-back fetches @0x0, 0x4 → `if_rsp_valid` at N+4 and N+9; data matches memory model.
- **Reset mid-read:** assert `rst` in RD_WAIT → no `d_rsp_valid`; state IDLE and all outputs at reset values next cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants, state/requester encodings and store-lane helpers for the
// fetch/data memory arbiter.
package mem_arb_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RSP     = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

    // Unsigned widths only exist for loads; stores stop at SW.
    function automatic logic data_access_err(input logic we, input logic [2:0] funct3,
                                             input logic [1:0] off);
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = off[0];
            F3_W:    err = (off != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | off[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] be;
        case (funct3)
            F3_B:    be = 4'b0001 << off;
            F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (funct3)
            F3_B:    lanes = {4{wdata[7:0]}};
            F3_H:    lanes = {2{wdata[15:0]}};
            F3_W:    lanes = wdata;
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a memory word and sign/zero-extends it.
module load_align
    import mem_arb_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select and extension
    always_comb begin
        case (offset)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        half_s = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_s[7]}}, byte_s};
            F3_H:    data = {{16{half_s[15]}}, half_s};
            F3_BU:   data = {24'd0, byte_s};
            F3_HU:   data = {16'd0, half_s};
            F3_W:    data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port word memory between instruction fetch and the
// load/store port; one transaction outstanding, responses in grant order.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        d_req_valid,
    input  logic        d_req_we,
    input  logic [2:0]  d_req_funct3,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_req_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] LAT_INIT   = 2'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_e  state_r, state_nxt_s;
    req_id_e     req_id_r;
    logic [3:0]  starve_cnt_r;
    logic [2:0]  funct3_r;
    logic [1:0]  off_r;
    logic [1:0]  lat_cnt_r;
    logic [31:0] rsp_data_r;
    logic        rsp_err_r;
    logic        grant_if_s, grant_d_s, grant_err_s, grant_read_s, grant_store_s;
    logic [31:0] sel_addr_s;
    logic [31:0] aligned_s;

    load_align u_load_align (
        .rdata  (mem_rdata),
        .offset (off_r),
        .funct3 (funct3_r),
        .data   (aligned_s)
    );

    // Grant decision and access classification for the current IDLE cycle
    always_comb begin
        grant_if_s = 1'b0;
        grant_d_s  = 1'b0;
        if ((state_r == ST_IDLE) && !rst) begin
            if (if_req_valid && d_req_valid) begin
                grant_if_s = (starve_cnt_r == STARVE_MAX);
                grant_d_s  = (starve_cnt_r != STARVE_MAX);
            end else begin
                grant_if_s = if_req_valid;
                grant_d_s  = d_req_valid;
            end
        end else begin
            grant_if_s = 1'b0;
            grant_d_s  = 1'b0;
        end
        sel_addr_s = grant_if_s ? if_req_addr : d_req_addr;
        if (grant_if_s) begin
            grant_err_s = (if_req_addr[1:0] != 2'b00);
        end else if (grant_d_s) begin
            grant_err_s = data_access_err(d_req_we, d_req_funct3, d_req_addr[1:0]);
        end else begin
            grant_err_s = 1'b0;
        end
        grant_store_s = grant_d_s && d_req_we && !grant_err_s;
        grant_read_s  = (grant_if_s || (grant_d_s && !d_req_we)) && !grant_err_s;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_read_s) begin
                    state_nxt_s = ST_RD_WAIT;
                end else if (grant_if_s || grant_d_s) begin
                    state_nxt_s = ST_RSP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: state_nxt_s = (lat_cnt_r == 2'd0) ? ST_RSP : ST_RD_WAIT;
            ST_RSP:     state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Transaction context, read countdown, captured response and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            req_id_r     <= REQ_IF;
            starve_cnt_r <= 4'd0;
            funct3_r     <= 3'd0;
            off_r        <= 2'd0;
            lat_cnt_r    <= 2'd0;
            rsp_data_r   <= 32'd0;
            rsp_err_r    <= 1'b0;
        end else begin
            if (!if_req_valid || grant_if_s) begin
                starve_cnt_r <= 4'd0;
            end else if ((state_r == ST_IDLE) && (starve_cnt_r != STARVE_MAX)) begin
                starve_cnt_r <= starve_cnt_r + 4'd1;
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
            if (grant_if_s || grant_d_s) begin
                req_id_r   <= grant_if_s ? REQ_IF : REQ_D;
                funct3_r   <= grant_if_s ? F3_W : d_req_funct3;
                off_r      <= sel_addr_s[1:0];
                lat_cnt_r  <= LAT_INIT;
                rsp_data_r <= 32'd0;
                rsp_err_r  <= grant_err_s;
            end else if (state_r == ST_RD_WAIT) begin
                if (lat_cnt_r == 2'd0) begin
                    rsp_data_r <= aligned_s;
                end else begin
                    lat_cnt_r <= lat_cnt_r - 2'd1;
                end
            end else begin
                rsp_data_r <= rsp_data_r;
            end
        end
    end

    // Port handshakes, response pulses and memory strobes
    always_comb begin
        if_req_ready = grant_if_s;
        d_req_ready  = grant_d_s;
        if_rsp_valid = !rst && (state_r == ST_RSP) && (req_id_r == REQ_IF);
        d_rsp_valid  = !rst && (state_r == ST_RSP) && (req_id_r == REQ_D);
        if_rsp_data  = if_rsp_valid ? rsp_data_r : 32'd0;
        if_rsp_err   = if_rsp_valid ? rsp_err_r : 1'b0;
        d_rsp_data   = d_rsp_valid ? rsp_data_r : 32'd0;
        d_rsp_err    = d_rsp_valid ? rsp_err_r : 1'b0;
        mem_en       = grant_read_s || grant_store_s;
        mem_we       = grant_store_s;
        if (grant_store_s) begin
            mem_addr  = {sel_addr_s[31:2], 2'b00};
            mem_be    = store_be(d_req_funct3, d_req_addr[1:0]);
            mem_wdata = store_wdata(d_req_funct3, d_req_wdata);
        end else if (grant_read_s) begin
            mem_addr  = {sel_addr_s[31:2], 2'b00};
            mem_be    = 4'b1111;
            mem_wdata = 32'd0;
        end else begin
            mem_addr  = 32'd0;
            mem_be    = 4'b0000;
            mem_wdata = 32'd0;
        end
    end

endmodule
